// File: rtl/div_radix2_if.sv
// rtl/div_radix2_if.sv - request/response bundle between a pipeline and the radix-2 divider
interface div_radix2_if;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;
  logic        stall;

  modport master (
    output signed_div, opdata1, opdata2, start, annul,
    input  result, ready, stall
  );

  modport slave (
    input  signed_div, opdata1, opdata2, start, annul,
    output result, ready, stall
  );
endinterface

// File: rtl/div_radix2.sv
// rtl/div_radix2.sv - 32-bit restoring radix-2 divider (DIV/DIVU), optional divide-by-zero shortcut under DIV_ZERO_CHECK_EN
module div_radix2 (
  input  logic         clk,
  input  logic         rst,
  div_radix2_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, BYZERO, ON, END} state_t;

  state_t      state;
  state_t      state_next;
  logic [4:0]  cnt;
  logic [31:0] rem;
  logic [31:0] quot;
  logic [31:0] dsr;
  logic        neg_quot;
  logic        neg_rem;
  logic [63:0] result_q;
`ifdef DIV_ZERO_CHECK_EN
  logic [31:0] dividend_raw;
`endif

  logic        neg_op1;
  logic        neg_op2;
  logic [32:0] rem_sh;
  logic [32:0] rem_diff;
  logic        fits;
  logic [31:0] rem_step;
  logic [31:0] quot_step;
  logic [31:0] quot_final;
  logic [31:0] rem_final;

  // Operand sign handling only applies in signed mode
  assign neg_op1 = bus.signed_div & bus.opdata1[31];
  assign neg_op2 = bus.signed_div & bus.opdata2[31];

  // One restoring step: shift {rem, quot} left, subtract divisor when it fits
  always_comb begin
    rem_sh    = {rem, quot[31]};
    rem_diff  = rem_sh - {1'b0, dsr};
    fits      = (rem_sh >= {1'b0, dsr});
    rem_step  = fits ? rem_diff[31:0] : rem_sh[31:0];
    quot_step = {quot[30:0], fits};
    quot_final = neg_quot ? (32'd0 - quot_step) : quot_step;
    rem_final  = neg_rem  ? (32'd0 - rem_step)  : rem_step;
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state logic; annul only matters while an operation is in flight
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
`ifdef DIV_ZERO_CHECK_EN
          state_next = (bus.opdata2 == 32'd0) ? BYZERO : ON;
`else
          state_next = ON;
`endif
        end
      end
      BYZERO:  state_next = bus.annul ? IDLE : END;
      ON: begin
        if (bus.annul)          state_next = IDLE;
        else if (cnt == 5'd31)  state_next = END;
        else                    state_next = ON;
      end
      END:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    bus.stall = 1'b0;
    bus.ready = 1'b0;
    case (state)
      IDLE:    bus.stall = bus.start;
      BYZERO:  bus.stall = 1'b1;
      ON:      bus.stall = 1'b1;
      END:     bus.ready = 1'b1;
      default: bus.stall = 1'b0;
    endcase
  end

  // Datapath: latch magnitudes on start, iterate in ON, write result on completion only
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= 5'd0;
      rem      <= 32'd0;
      quot     <= 32'd0;
      dsr      <= 32'd0;
      neg_quot <= 1'b0;
      neg_rem  <= 1'b0;
      result_q <= 64'h0;
`ifdef DIV_ZERO_CHECK_EN
      dividend_raw <= 32'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            cnt      <= 5'd0;
            rem      <= 32'd0;
            quot     <= neg_op1 ? (32'd0 - bus.opdata1) : bus.opdata1;
            dsr      <= neg_op2 ? (32'd0 - bus.opdata2) : bus.opdata2;
            neg_quot <= neg_op1 ^ neg_op2;
            neg_rem  <= neg_op1;
`ifdef DIV_ZERO_CHECK_EN
            dividend_raw <= bus.opdata1;
`endif
          end
        end
        ON: begin
          cnt  <= cnt + 5'd1;
          rem  <= rem_step;
          quot <= quot_step;
          if (cnt == 5'd31 && !bus.annul)
            result_q <= {rem_final, quot_final};
        end
        BYZERO: begin
`ifdef DIV_ZERO_CHECK_EN
          if (!bus.annul)
            result_q <= {dividend_raw, 32'hFFFF_FFFF};
`endif
        end
        default: ;
      endcase
    end
  end

  assign bus.result = result_q;

endmodule

// File: tb/tb_div_radix2.sv
// tb/tb_div_radix2.sv - directed-vector bench for div_radix2
module tb_div_radix2;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  div_radix2_if bus ();

  div_radix2 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef DIV_ZERO_CHECK_EN
  localparam int ZERO_LAT = 2;
`else
  localparam int ZERO_LAT = 33;
`endif

  // Issue one operation at a negedge and wait (bounded) for ready
  task automatic run_op(input logic sd, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [63:0] res,
                        output bit stall_ok, output bit end_stall_low);
    bus.signed_div = sd;
    bus.opdata1    = a;
    bus.opdata2    = b;
    bus.start      = 1'b1;
    #1;
    stall_ok      = (bus.stall === 1'b1);
    end_stall_low = 1'b0;
    lat           = -1;
    res           = 64'hx;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (bus.ready === 1'b1) begin
        lat           = c;
        res           = bus.result;
        end_stall_low = (bus.stall === 1'b0);
        bus.start     = 1'b0;
        break;
      end
      if (bus.stall !== 1'b1) stall_ok = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst        = 1'b0;
    bus.start  = 1'b0;
    bus.annul  = 1'b0;
    bus.signed_div = 1'b0;
    bus.opdata1 = 32'd0;
    bus.opdata2 = 32'd0;
    #2;
    vectors++;
    if (bus.ready !== 1'b0 || bus.result !== 64'h0 || bus.stall !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: ready=%b stall=%b result=%h, want 0 0 0", bus.ready, bus.stall, bus.result);
    end
    bus.start = 1'b1;
    #1;
    vectors++;
    if (bus.stall !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_stall_follows_start: stall=%b want 1", bus.stall);
    end
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_op(input string name, input logic sd, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp_res, input int exp_lat);
    int lat; logic [63:0] res; bit s_ok; bit e_ok;
    run_op(sd, a, b, lat, res, s_ok, e_ok);
    vectors++;
    if (lat != exp_lat) begin
      miscompares++;
      $display("FAIL %s_latency: got %0d want %0d", name, lat, exp_lat);
    end
    vectors++;
    if (res !== exp_res) begin
      miscompares++;
      $display("FAIL %s_result: got %h want %h", name, res, exp_res);
    end
    vectors++;
    if (!s_ok || !e_ok) begin
      miscompares++;
      $display("FAIL %s_stall: busy_high=%b end_low=%b want 1 1", name, s_ok, e_ok);
    end
    @(negedge clk);
  endtask

  task automatic test_unsigned;
    check_op("u100_7",   1'b0, 32'd100,       32'd7,         {32'd2, 32'd14},         33);
    check_op("umax_1",   1'b0, 32'hFFFF_FFFF, 32'd1,         {32'd0, 32'hFFFF_FFFF},  33);
    check_op("u1_max",   1'b0, 32'd1,         32'hFFFF_FFFF, {32'd1, 32'd0},          33);
    check_op("u_neg7_2", 1'b0, 32'hFFFF_FFF9, 32'd2,         {32'd1, 32'h7FFF_FFFC},  33);
  endtask

  task automatic test_signed;
    check_op("s_m7_2",  1'b1, 32'hFFFF_FFF9, 32'd2,         {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
    check_op("s_7_m2",  1'b1, 32'd7,         32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD},         33);
    check_op("s_m8_m3", 1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFD, {32'hFFFF_FFFE, 32'd2},         33);
  endtask

  task automatic test_overflow;
    check_op("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 33);
  endtask

  task automatic test_div_zero;
    check_op("u5_0", 1'b0, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, ZERO_LAT);
  endtask

  task automatic test_back_to_back;
    int first_at; int second_at; logic [63:0] r1; logic [63:0] r2;
    first_at = -1; second_at = -1; r1 = 64'hx; r2 = 64'hx;
    bus.signed_div = 1'b0;
    bus.opdata1 = 32'd100;
    bus.opdata2 = 32'd7;
    bus.start   = 1'b1;
    for (int c = 1; c <= 120; c++) begin
      @(negedge clk);
      if (bus.ready === 1'b1) begin
        if (first_at < 0) begin
          first_at    = c;
          r1          = bus.result;
          bus.opdata1 = 32'd9;
          bus.opdata2 = 32'd3;
        end else begin
          second_at = c;
          r2        = bus.result;
          bus.start = 1'b0;
          break;
        end
      end
    end
    bus.start = 1'b0;
    vectors++;
    if (r1 !== {32'd2, 32'd14}) begin
      miscompares++;
      $display("FAIL b2b_first_result: got %h want %h", r1, {32'd2, 32'd14});
    end
    vectors++;
    if (first_at < 0 || second_at < 0 || (second_at - first_at) != 34) begin
      miscompares++;
      $display("FAIL b2b_gap: first=%0d second=%0d want gap 34", first_at, second_at);
    end
    vectors++;
    if (r2 !== {32'd0, 32'd3}) begin
      miscompares++;
      $display("FAIL b2b_second_result: got %h want %h", r2, {32'd0, 32'd3});
    end
    @(negedge clk);
  endtask

  task automatic test_annul(input logic [63:0] prior);
    bit pulsed;
    pulsed = 1'b0;
    bus.signed_div = 1'b0;
    bus.opdata1 = 32'd1000;
    bus.opdata2 = 32'd3;
    bus.start   = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (bus.ready === 1'b1) pulsed = 1'b1;
    end
    bus.annul = 1'b1;
    bus.start = 1'b0;
    @(negedge clk);
    bus.annul = 1'b0;
    vectors++;
    if (bus.stall !== 1'b0) begin
      miscompares++;
      $display("FAIL annul_to_idle: stall=%b want 0", bus.stall);
    end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.ready === 1'b1) pulsed = 1'b1;
    end
    vectors++;
    if (pulsed) begin
      miscompares++;
      $display("FAIL annul_no_ready: ready pulsed=1 want 0");
    end
    vectors++;
    if (bus.result !== prior) begin
      miscompares++;
      $display("FAIL annul_result_held: got %h want %h", bus.result, prior);
    end
  endtask

  task automatic test_reset_mid;
    bit pulsed;
    pulsed = 1'b0;
    bus.signed_div = 1'b0;
    bus.opdata1 = 32'd77;
    bus.opdata2 = 32'd5;
    bus.start   = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (bus.ready === 1'b1) pulsed = 1'b1;
    end
    bus.start = 1'b0;
    rst = 1'b0;
    #1;
    vectors++;
    if (bus.result !== 64'h0 || bus.ready !== 1'b0 || bus.stall !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_immediate: result=%h ready=%b stall=%b want 0 0 0", bus.result, bus.ready, bus.stall);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.ready === 1'b1) pulsed = 1'b1;
    end
    vectors++;
    if (pulsed || bus.result !== 64'h0) begin
      miscompares++;
      $display("FAIL reset_mid_discard: pulsed=%b result=%h want 0 0", pulsed, bus.result);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_unsigned();
    test_signed();
    test_overflow();
    test_div_zero();
    test_back_to_back();
    test_annul({32'd0, 32'd3});
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/div_radix2.md
DIV_RADIX2 -- requirements
Module: div_radix2

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port signed_div, input, 1 bit: 1 = signed (DIV), 0 = unsigned (DIVU); sampled with start.
REQ-004 SHALL have port opdata1, input, 32 bits: dividend; sampled with start.
REQ-005 SHALL have port opdata2, input, 32 bits: divisor; sampled with start.
REQ-006 SHALL have port start, input, 1 bit: the requester holds it high until ready is seen high.
REQ-007 SHALL have port annul, input, 1 bit: abort the operation in flight.
REQ-008 SHALL have port result, output, 64 bits: {remainder[63:32], quotient[31:0]}, mapping to {HI, LO}.
REQ-009 SHALL have port ready, output, 1 bit: result valid, one-cycle pulse.
REQ-010 SHALL have port stall, output, 1 bit: pipeline hold request.

Function
REQ-011 SHALL implement FSM states IDLE, BYZERO, ON, END.
REQ-012 IDLE, start=1: SHALL latch operands and signed_div.
  - Go to BYZERO if the macro is defined and opdata2==0.
  - Otherwise clear the 5-bit iteration counter and go to ON.
REQ-013 ON SHALL perform one restoring radix-2 step per cycle on operand magnitudes.
  - Step: shift {rem, quot} left 1; if rem >= |divisor|, subtract and set quot[0]=1.
  - Leave for END after counter value 31, i.e. 32 cycles.
REQ-014 Signed mode, magnitudes: negate an operand only when its bit 31 = 1 and signed_div = 1.
REQ-015 Signed mode, final sign fix: quotient negative iff dividend sign XOR divisor sign; remainder takes the dividend sign.
REQ-016 Overflow case 0x80000000 / 0xFFFFFFFF (signed) SHALL wrap: quotient 0x80000000, remainder 0.
REQ-017 END SHALL drive ready=1 and the final result for exactly one cycle, then go to IDLE unconditionally.
REQ-018 result SHALL hold its last written value in every state except END and BYZERO completion.
REQ-019 stall SHALL be combinational: 1 when (state==IDLE and start=1), or state is BYZERO or ON; 0 in END.
REQ-020 ready latency: start sampled at edge 0 -> ready high in cycle 33 on the normal path.
REQ-021 annul=1 in BYZERO or ON SHALL return the FSM to IDLE next edge.
  - ready stays 0 and result is unchanged.
  - annul in IDLE or END has no effect.
REQ-022 start=1 in IDLE directly after END SHALL begin a new operation (back-to-back).
REQ-023 start changing or operands changing while in ON SHALL be ignored.

Reset
REQ-024 rst=0 SHALL immediately force:
  - state=IDLE, counter=0, result=64'h0, ready=0;
  - stall reflects IDLE, i.e. equals start.
REQ-025 Reset mid-operation SHALL discard the operation with no ready pulse.

Configuration
REQ-026 Macro DIV_ZERO_CHECK_EN defined: divisor 0 SHALL go IDLE -> BYZERO -> END.
  - result = {opdata1 latched, 32'hFFFFFFFF}.
  - ready in cycle 2.
REQ-027 Macro DIV_ZERO_CHECK_EN undefined: divisor 0 SHALL take the normal 32-step path.
  - Result is whatever the datapath yields.
  - Unsigned: quotient 0xFFFFFFFF, remainder = dividend.

Verification
REQ-028 Unsigned, opdata1=100, opdata2=7, start held -> stall=1 cycles 0..32, ready=1 cycle 33, result={32'd2, 32'd14}.
REQ-029 Signed, -7 / 2 (0xFFFFFFF9 / 0x2) -> result={32'hFFFFFFFF, 32'hFFFFFFFD}; signed 7 / -2 -> quotient 0xFFFFFFFD, remainder 1.
REQ-030 Signed, 0x80000000 / 0xFFFFFFFF -> result={32'h0, 32'h80000000}, no hang.
REQ-031 Macro defined, unsigned 5 / 0 -> ready cycle 2, result={32'd5, 32'hFFFFFFFF}; macro undefined -> ready cycle 33, same value.
REQ-032 Abort and reset:
  - annul=1 at cycle 10 -> IDLE next edge, ready never pulses, result equals prior value.
  - rst=0 at cycle 20 -> result=0 immediately, no ready.
REQ-033 Back-to-back: 100/7 then 9/3 with start re-asserted the cycle after END -> second ready 34 cycles after the first, result={0, 3}.
